// File: rtl/mem_arbiter_pkg.sv
// Shared types and parameter defaults for the multi-channel memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEF     = 17;
    localparam int DW_DEF     = 32;
    localparam int NCH_DEF    = 2;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request channels and single-port RAM signals seen by the arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int NCH = NCH_DEF
);

    logic [NCH-1:0]        req;
    logic [NCH-1:0]        we;
    logic [NCH*AW-1:0]     addr;
    logic [NCH*DW-1:0]     wdata;
    logic [NCH*DW/8-1:0]   be;
    logic [NCH-1:0]        gnt;
    logic [NCH-1:0]        rvalid;
    logic [DW-1:0]         rdata;
    logic                  ram_en;
    logic [DW/8-1:0]       ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DW-1:0]         ram_wdata;
    logic [DW-1:0]         ram_rdata;

    // The master side bundles the requesters and the RAM itself.
    modport master (
        output req, we, addr, wdata, be, ram_rdata,
        input  gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  req, we, addr, wdata, be, ram_rdata,
        output gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin picker: searches upward from the channel after the last grant.
module rr_arbiter #(
    parameter int NCH = 2,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  lastGnt_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o,
    output logic           valid_o
);

    int   chan;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        chan  = 0;
        for (int k = 1; k <= NCH; k++) begin
            chan = (int'(lastGnt_i) + k) % NCH;
            if (!found && req_i[chan]) begin
                found       = 1'b1;
                gnt_o[chan] = 1'b1;
                idx_o       = IW'(chan);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel single-port RAM arbiter: one access per grant, reads
// return RD_LAT cycles later while further grants are held off.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int NCH    = NCH_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    mem_arbiter_if.slave bus
);

    localparam int IW = $clog2(NCH);
    localparam int BW = DW / 8;

    state_e          state_q, state_d;
    logic [2:0]      rdCnt_q, rdCnt_d;
    logic [IW-1:0]   lastGnt_q, lastGnt_d;
    logic [IW-1:0]   pendCh_q, pendCh_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [NCH-1:0]  arbGnt;
    logic [IW-1:0]   arbIdx;
    logic            arbValid;
    logic            rvNow;
    logic            arbEn;

    rr_arbiter #(
        .NCH (NCH),
        .IW  (IW)
    ) u_rr (
        .req_i     (bus.req),
        .lastGnt_i (lastGnt_q),
        .gnt_o     (arbGnt),
        .idx_o     (arbIdx),
        .valid_o   (arbValid)
    );

    // The rvalid cycle doubles as an IDLE cycle so reads can run back to back.
    always_comb begin
        rvNow     = (state_q == RD_WAIT) && (rdCnt_q == 3'd1);
        arbEn     = !rstn && ((state_q == IDLE) || rvNow);
        state_d   = state_q;
        rdCnt_d   = rdCnt_q;
        lastGnt_d = lastGnt_q;
        pendCh_d  = pendCh_q;
        rdata_d   = rdata_q;

        bus.gnt       = '0;
        bus.rvalid    = '0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = '0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;

        if (state_q == RD_WAIT) begin
            rdCnt_d = rdCnt_q - 3'd1;
        end

        if (rvNow) begin
            bus.rvalid[pendCh_q] = 1'b1;
            rdata_d              = bus.ram_rdata;
            state_d              = IDLE;
        end

        if (arbEn && arbValid) begin
            bus.gnt       = arbGnt;
            bus.ram_en    = 1'b1;
            bus.ram_addr  = bus.addr[arbIdx*AW +: AW];
            bus.ram_wdata = bus.wdata[arbIdx*DW +: DW];
            lastGnt_d     = arbIdx;
            if (bus.we[arbIdx]) begin
                bus.ram_we = bus.be[arbIdx*BW +: BW];
            end else begin
                state_d  = RD_WAIT;
                rdCnt_d  = 3'(RD_LAT);
                pendCh_d = arbIdx;
            end
        end

        bus.rdata = rdata_d;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= IDLE;
            rdCnt_q   <= '0;
            lastGnt_q <= IW'(NCH - 1);
            pendCh_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rdCnt_q   <= rdCnt_d;
            lastGnt_q <= lastGnt_d;
            pendCh_q  <= pendCh_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AW, 17, word-address width.
- DW, 32, data width; multiple of 8.
- NCH, 2, request channels; 2..8.
- RD_LAT, 1, RAM read latency in cycles; 1..4.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on the rising edge.
- rstn, in, 1, reset; asynchronous, active-high (asserted = 1).
- req, in, NCH, per-channel request, held until granted.
- we, in, NCH, per-channel write (1) / read (0).
- addr, in, NCH*AW, per-channel address; channel i occupies bits [i*AW +: AW].
- wdata, in, NCH*DW, per-channel write data.
- be, in, NCH*DW/8, per-channel byte enables for writes.
- gnt, out, NCH, one-hot acceptance pulse.
- rvalid, out, NCH, one-hot read-data-valid pulse.
- rdata, out, DW, read data shared by all channels.
- ram_en, out, 1, RAM enable.
- ram_we, out, DW/8, RAM byte write enables.
- ram_addr, out, AW, RAM address.
- ram_wdata, out, DW, RAM write data.
- ram_rdata, in, DW, RAM read data, valid RD_LAT cycles after ram_en with ram_we == 0.

Function
REQ-003 The block SHALL have two states, IDLE and RD_WAIT.
REQ-004 In IDLE with any req bit set, the block SHALL grant exactly one channel in the same cycle (combinational gnt).
- That cycle it SHALL drive ram_en = 1, ram_addr and ram_wdata from the granted channel, and ram_we = be[ch] when we[ch] = 1, else 0.
REQ-005 Channel selection SHALL be round-robin: search starts at (last granted + 1) mod NCH; after reset the last-granted pointer = NCH-1, so channel 0 has top priority.
REQ-006 A granted write SHALL complete in the grant cycle; the state remains IDLE, allowing one write per cycle.
REQ-007 A granted read SHALL move the state to RD_WAIT and load the latency counter. rvalid[ch] SHALL be asserted exactly RD_LAT cycles after the grant, with rdata = ram_rdata in that cycle.
REQ-008 In RD_WAIT no grant SHALL be issued, except in the rvalid cycle.
- In the rvalid cycle the block SHALL behave as IDLE for arbitration, giving back-to-back reads: one read per RD_LAT cycles.
REQ-009 A write with be = 0 SHALL still be granted, with ram_en = 1 and ram_we = 0; nothing is written and no rvalid follows.
REQ-010 be SHALL be ignored for reads.
REQ-011 When no grant is issued, ram_en and ram_we SHALL be 0. rdata SHALL hold its last rvalid value.
REQ-012 Requests arriving while in RD_WAIT SHALL wait. A requester dropping req before its grant is legal and SHALL produce no RAM access.

Reset
REQ-013 While rstn = 1 the block SHALL hold these values:
- state = IDLE, latency counter = 0, last-granted pointer = NCH-1.
- gnt = 0, rvalid = 0, rdata = 0, ram_en = 0, ram_we = 0.
REQ-014 Reset asserted during RD_WAIT SHALL discard the pending read; no rvalid is produced after reset release.

Structure
REQ-015 Package mem_arb_pkg SHALL hold the state enum {IDLE, RD_WAIT} and the default values of AW, DW, NCH and RD_LAT.
REQ-016 Round-robin selection SHALL live in sub-module rr_arbiter.
- Inputs: req[NCH] and the last-granted pointer.
- Outputs: one-hot grant and the encoded index.

Verification
REQ-017 The bench SHALL cover these directed scenarios (NCH = 2, RD_LAT = 1 unless stated):
- Simultaneous reads: req = 2'b11, both reads, just after reset → gnt = 01 in the first cycle; rvalid = 01 the next cycle together with gnt = 10; rvalid = 10 one cycle later.
- Continuous load: req = 11, all writes, sustained → gnt alternates 01, 10, 01, ... one per cycle; ram_we = be of the granted channel.
- Byte write then read: channel 0 writes 0xAABBCCDD to address 5 with be = 4'b0101, over prior content 0 → a later read of address 5 returns 0x00BB00DD.
- Latency 3: RD_LAT = 3, channel 1 reads with channel 0 requesting at grant+1 → channel 0 is not granted until the cycle rvalid[1] asserts, 3 cycles after the first grant.
- Reset during read: rstn pulsed high at grant+1 of a read with RD_LAT = 3 → no rvalid ever asserted; next grant after release goes to channel 0.
- Empty write: be = 0 → gnt = 1, ram_en = 1, ram_we = 0; RAM content unchanged.
